mem_access_stage: RTL and testbench

Load/store stage directly downstream of the 32-bit ALU. It consumes the ALU's effective address (rs + sign-extended immediate), the store data (rt) and the opcode. It runs one word-wide memory transaction over a valid/ready bus and returns load data, or the sc status, for writeback. It also owns byte-lane steering, alignment checks and the ll/sc link register.

---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 tb/tb_mem_access_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store stage.
// Holds the memory opcodes (also used by the ALU decode), the stage FSM
// states, the access-size encoding and small opcode classification helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW, OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_SB, OP_LBU: return BYTE;
            OP_SH, OP_LHU: return HALF;
            default:       return WORD;
        endcase
    endfunction

    // Ops that drive a bus write (sc writes only when it reaches the bus).
    function automatic logic op_writes(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word bus.
//   size     : access size
//   addr_lo  : byte offset within the word
//   st_data  : register value to store
//   ld_word  : word returned by the bus
//   be       : byte enables (be[0] = byte 0)
//   st_lanes : store data replicated across lanes
//   ld_data  : addressed byte/halfword zero-extended, or the full word
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // Move the addressed byte/halfword down to bit 0 before masking.
    assign ld_shift = ld_word >> {addr_lo, 3'b000};

    always_comb begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_word;
        case (size)
            BYTE: begin
                be       = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {24'b0, ld_shift[7:0]};
            end
            HALF: begin
                be       = 4'b0011 << addr_lo;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {16'b0, ld_shift[15:0]};
            end
            default: begin
                be       = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage behind the ALU: one word-wide valid/ready bus transaction
// per instruction, with lane steering, alignment faults and the ll/sc link.
//   in_*   : request from the ALU (in_ready high only in IDLE)
//   mem_*  : word bus; request fields held stable while mem_req is high
//   wb_*   : one-cycle writeback pulse with load data or sc status
//   misalign : access faulted, qualified by wb_valid
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign
);

    state_t            state;
    logic [5:0]        op_q;
    size_t             size_q;
    logic [1:0]        lo_q;
    logic              link_valid;
    logic [ADDR_W-3:0] link_addr;

    size_t             in_size;
    logic [ADDR_W-3:0] in_word;
    logic              in_mis;
    logic              sc_hit;

    size_t             al_size;
    logic [1:0]        al_lo;
    logic [3:0]        al_be;
    logic [31:0]       al_st;
    logic [31:0]       al_ld;

    assign in_size = op_size(in_opcode);
    assign in_word = in_addr[ADDR_W-1:2];
    assign in_mis  = ((in_size == HALF) && in_addr[0]) ||
                     ((in_size == WORD) && (in_addr[1:0] != 2'b00));
    assign sc_hit  = link_valid && (link_addr == in_word);

    // One aligner serves both ends: in IDLE it steers the incoming store,
    // in REQ it extracts the load from the returning word.
    assign al_size = (state == IDLE) ? in_size : size_q;
    assign al_lo   = (state == IDLE) ? in_addr[1:0] : lo_q;

    mem_lane_align u_align (
        .size     (al_size),
        .addr_lo  (al_lo),
        .st_data  (in_wdata),
        .ld_word  (mem_rdata),
        .be       (al_be),
        .st_lanes (al_st),
        .ld_data  (al_ld)
    );

    assign in_ready = (state == IDLE);
    assign mem_req  = (state == REQ);
    assign wb_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            size_q     <= WORD;
            lo_q       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            misalign   <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && op_supported(in_opcode)) begin
                        op_q      <= in_opcode;
                        size_q    <= in_size;
                        lo_q      <= in_addr[1:0];
                        wb_rd     <= in_rd;
                        mem_we    <= op_writes(in_opcode);
                        mem_addr  <= in_word;
                        mem_be    <= al_be;
                        mem_wdata <= al_st;
                        wb_data   <= '0;
                        wb_we     <= 1'b0;
                        misalign  <= 1'b0;
                        if (in_mis) begin
                            misalign <= 1'b1;
                            state    <= DONE;
                        end else if ((in_opcode == OP_SC) && !sc_hit) begin
                            // sc fails without touching the bus; status 0.
                            wb_we      <= 1'b1;
                            link_valid <= 1'b0;
                            state      <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state <= DONE;
                        case (op_q)
                            OP_LW, OP_LBU, OP_LHU: begin
                                wb_we   <= 1'b1;
                                wb_data <= al_ld;
                            end
                            OP_LL: begin
                                wb_we      <= 1'b1;
                                wb_data    <= al_ld;
                                link_valid <= 1'b1;
                                link_addr  <= mem_addr;
                            end
                            OP_SC: begin
                                wb_we      <= 1'b1;
                                wb_data    <= 32'd1;
                                link_valid <= 1'b0;
                            end
                            default: begin
                                // Plain store: breaks a link on the same word.
                                if (link_valid && (link_addr == mem_addr))
                                    link_valid <= 1'b0;
                            end
                        endcase
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_opcode = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid, wb_we, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
        logic        wb_we;
        logic [31:0] data;
        logic        mis;
        int          lat;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wdata, rdata;
        int          dly;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic        req_seen, unstable, we;
        logic [29:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wb_we;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        int          lat;
        logic        pulse_ok;
    } obs_t;

    // Reference link register for the random phase.
    logic        m_lv = 1'b0;
    logic [29:0] m_lw = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                                input int dly, input logic req, we, input logic [3:0] be,
                                input logic [31:0] ewd, input logic chkwd, wbwe,
                                input logic [31:0] data, input logic mis, input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
        v.e.req = req; v.e.we = we; v.e.be = be; v.e.wdata = ewd; v.e.chk_wd = chkwd;
        v.e.wb_we = wbwe; v.e.data = data; v.e.mis = mis; v.e.lat = lat;
        return v;
    endfunction

    // Called at a negedge with the stage idle; returns at a negedge, idle again.
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                          input logic [4:0] rd, input int dly, output obs_t r);
        int cyc;
        int waits;
        r.req_seen = 0; r.unstable = 0; r.we = 0; r.maddr = '0; r.be = '0; r.wdata = '0;
        r.wb_we = 0; r.data = '0; r.rd = '0; r.mis = 0; r.lat = 0; r.pulse_ok = 0;
        in_valid = 1'b1; in_opcode = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_opcode = 6'h3f; in_addr = $urandom; in_wdata = $urandom;
        cyc = 1; waits = 0;
        while (wb_valid !== 1'b1 && cyc < 40) begin
            if (mem_req === 1'b1) begin
                if (!r.req_seen) begin
                    r.we = mem_we; r.maddr = mem_addr; r.be = mem_be; r.wdata = mem_wdata;
                end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {r.we, r.maddr, r.be, r.wdata}) begin
                    r.unstable = 1'b1;
                end
                r.req_seen = 1'b1;
                if (waits >= dly) begin
                    mem_ready = 1'b1; mem_rdata = rdata;
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom; waits++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        r.lat = cyc; r.wb_we = wb_we; r.data = wb_data; r.rd = wb_rd; r.mis = misalign;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        r.pulse_ok = (wb_valid === 1'b0) && (in_ready === 1'b1) && (mem_req === 1'b0);
    endtask

    task automatic check_op(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                            input exp_t e, input obs_t r);
        chk({tag, "_lat"}, 64'(r.lat), 64'(e.lat));
        chk({tag, "_req"}, 64'(r.req_seen), 64'(e.req));
        if (e.req) begin
            chk({tag, "_maddr"}, 64'(r.maddr), 64'(addr[31:2]));
            chk({tag, "_be"}, 64'(r.be), 64'(e.be));
            chk({tag, "_we"}, 64'(r.we), 64'(e.we));
            chk({tag, "_stable"}, 64'(r.unstable), 64'd0);
            if (e.chk_wd) chk({tag, "_wdata"}, 64'(r.wdata), 64'(e.wdata));
        end
        chk({tag, "_mis"}, 64'(r.mis), 64'(e.mis));
        chk({tag, "_wbwe"}, 64'(r.wb_we), 64'(e.wb_we));
        if (e.wb_we) chk({tag, "_data"}, 64'(r.data), 64'(e.data));
        chk({tag, "_rd"}, 64'(r.rd), 64'(rd));
        chk({tag, "_pulse"}, 64'(r.pulse_ok), 64'd1);
    endtask

    // Reference behaviour from the access rules, with its own link state.
    task automatic model_op(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                            input int dly, output exp_t e);
        int          sz, off;
        logic        is_st, is_ld;
        logic [63:0] mask;
        sz  = (op == OP_SB || op == OP_LBU) ? 1 : (op == OP_SH || op == OP_LHU) ? 2 : 4;
        off = int'(addr[1:0]);
        is_st = (op == OP_SB || op == OP_SH || op == OP_SW);
        is_ld = (op == OP_LW || op == OP_LBU || op == OP_LHU || op == OP_LL);
        e.req = 0; e.we = 0; e.be = '0; e.wdata = '0; e.chk_wd = 0;
        e.wb_we = 0; e.data = '0; e.mis = 0; e.lat = 1;
        if ((off % sz) != 0) begin
            e.mis = 1;
        end else if (op == OP_SC && !(m_lv && m_lw == addr[31:2])) begin
            e.wb_we = 1; e.data = 0; m_lv = 0;
        end else begin
            e.req = 1; e.lat = 2 + dly;
            e.we = is_st || (op == OP_SC);
            e.chk_wd = e.we;
            e.be = 4'(((1 << sz) - 1) << off);
            e.wdata = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
            mask = (64'd1 << (8 * sz)) - 64'd1;
            if (is_ld) begin
                e.wb_we = 1;
                e.data = 32'((64'(rdata) >> (8 * off)) & mask);
            end
            if (op == OP_SC) begin e.wb_we = 1; e.data = 1; m_lv = 0; end
            if (op == OP_LL) begin m_lv = 1; m_lw = addr[31:2]; end
            if (is_st && m_lv && m_lw == addr[31:2]) m_lv = 0;
        end
    endtask

    initial begin
        vec_t        vt[$];
        obs_t        r;
        exp_t        e;
        logic [5:0]  ops[8];
        logic [31:0] bases[3];
        logic [31:0] a, wd, rdt;
        logic [4:0]  rd;
        int          dly, off;

        ops = '{OP_SB, OP_SH, OP_SW, OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SC};
        bases = '{32'h200, 32'h204, 32'h300};

        //              op      addr     wdata         rdata       d req we be      ewdata     chk wbwe data         mis lat
        vt.push_back(mk(OP_SW,  32'h104, 32'hDEADBEEF, 32'h0,      0, 1, 1, 4'b1111, 32'hDEADBEEF, 1, 0, 32'h0,        0, 2));
        vt.push_back(mk(OP_LBU, 32'h103, 32'h0,        32'h80FF1234, 3, 1, 0, 4'b1000, 32'h0,      0, 1, 32'h00000080, 0, 5));
        vt.push_back(mk(OP_SH,  32'h102, 32'h0000ABCD, 32'h0,      1, 1, 1, 4'b1100, 32'hABCDABCD, 1, 0, 32'h0,        0, 3));
        vt.push_back(mk(OP_LW,  32'h102, 32'h0,        32'h0,      0, 0, 0, 4'b0000, 32'h0,      0, 0, 32'h0,        1, 1));
        vt.push_back(mk(OP_LHU, 32'h102, 32'h0,        32'h80FF1234, 0, 1, 0, 4'b1100, 32'h0,      0, 1, 32'h000080FF, 0, 2));
        vt.push_back(mk(OP_LHU, 32'h101, 32'h0,        32'h0,      0, 0, 0, 4'b0000, 32'h0,      0, 0, 32'h0,        1, 1));
        vt.push_back(mk(OP_LL,  32'h200, 32'h0,        32'h11223344, 0, 1, 0, 4'b1111, 32'h0,      0, 1, 32'h11223344, 0, 2));
        vt.push_back(mk(OP_SC,  32'h200, 32'h00000055, 32'h0,      0, 1, 1, 4'b1111, 32'h00000055, 1, 1, 32'h1,        0, 2));
        vt.push_back(mk(OP_SC,  32'h200, 32'h00000066, 32'h0,      0, 0, 0, 4'b0000, 32'h0,      0, 1, 32'h0,        0, 1));
        vt.push_back(mk(OP_LL,  32'h200, 32'h0,        32'hCAFEF00D, 1, 1, 0, 4'b1111, 32'h0,      0, 1, 32'hCAFEF00D, 0, 3));
        vt.push_back(mk(OP_SB,  32'h201, 32'h000000A5, 32'h0,      0, 1, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 32'h0,        0, 2));
        vt.push_back(mk(OP_SC,  32'h200, 32'h00000077, 32'h0,      0, 0, 0, 4'b0000, 32'h0,      0, 1, 32'h0,        0, 1));
        vt.push_back(mk(OP_LL,  32'h200, 32'h0,        32'h0,      0, 1, 0, 4'b1111, 32'h0,      0, 1, 32'h0,        0, 2));
        vt.push_back(mk(OP_SW,  32'h300, 32'h00000001, 32'h0,      0, 1, 1, 4'b1111, 32'h00000001, 1, 0, 32'h0,        0, 2));
        vt.push_back(mk(OP_SC,  32'h200, 32'h12345678, 32'h0,      2, 1, 1, 4'b1111, 32'h12345678, 1, 1, 32'h1,        0, 4));
        vt.push_back(mk(OP_SC,  32'h202, 32'h0,        32'h0,      0, 0, 0, 4'b0000, 32'h0,      0, 0, 32'h0,        1, 1));

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wb", 64'({wb_valid, wb_we, misalign}), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            rd = 5'(i + 3);
            run_op(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rdata, rd, vt[i].dly, r);
            check_op($sformatf("v%0d", i), vt[i].addr, rd, vt[i].e, r);
        end

        // Unsupported opcode is dropped: stage stays idle, no bus, no writeback.
        in_valid = 1'b1; in_opcode = 6'h2a; in_addr = 32'h200; in_rd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("unsup%0d", k), 64'({in_ready, mem_req, wb_valid}), 64'b100);
        end
        in_valid = 1'b0;

        // Reset during REQ: link set first, then an ll stalls and is reset away.
        run_op(OP_LL, 32'h200, 32'h0, 32'h0, 5'd1, 0, r);
        chk("pre_rst_ll", 64'(r.lat), 64'd2);
        mem_ready = 1'b0;
        in_valid = 1'b1; in_opcode = OP_LW; in_addr = 32'h200; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midreq_req", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreq_drop", 64'({mem_req, wb_valid, in_ready}), 64'b001);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("postrst%0d", k), 64'({wb_valid, mem_req, in_ready}), 64'b001);
        end
        run_op(OP_SC, 32'h200, 32'h5, 32'h0, 5'd6, 0, r);
        e = mk(OP_SC, 32'h200, 32'h5, 0, 0, 0, 0, 4'b0, 0, 0, 1, 0, 0, 1).e;
        check_op("sc_after_rst", 32'h200, 5'd6, e, r);

        // Randomized ops over a few shared words so ll/sc/store interplay happens.
        m_lv = 1'b0;
        for (int n = 0; n < 200; n++) begin
            off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0;
            a   = bases[$urandom_range(0, 2)] + 32'(off);
            wd  = $urandom; rdt = $urandom; rd = 5'($urandom_range(0, 31));
            dly = int'($urandom_range(0, 3));
            ops[0] = ops[0];
            begin
                logic [5:0] op;
                op = ops[$urandom_range(0, 7)];
                model_op(op, a, wd, rdt, dly, e);
                run_op(op, a, wd, rdt, rd, dly, r);
                check_op($sformatf("r%0d_op%0h_a%0h", n, op, a), a, rd, e, r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
